// File: rtl/sym_fir_pkg.sv
// Shared constants, types and helpers for the symmetric FIR front end.
// Used by sym_tap_line, sym_pre_add and the downstream coefficient MAC.
package sym_fir_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_TAPS   = 8;

    // One pre-added pair at the default sample width (one bit of growth).
    typedef logic signed [DEF_DATA_W:0] pair_t;

    // Number of pre-add pairs for a given filter length; the odd centre
    // tap counts as a pair of its own.
    function automatic int pairs_f(input int taps);
        return (taps + 1) / 2;
    endfunction

endpackage

// File: rtl/sym_pre_add.sv
// Combinational pre-adder for one symmetric tap pair.
// Both operands are sign-extended by one bit, so the result cannot overflow.
// centre=1 marks the lone middle tap of an odd-length line: it passes a
// through on its own (or yields 0 in subtract mode).
module sym_pre_add #(
    parameter int DATA_W = 16
) (
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    input  logic                     sub,
    input  logic                     centre,
    output logic signed [DATA_W:0]   y
);

    logic signed [DATA_W:0] a_x;
    logic signed [DATA_W:0] b_x;

    // Sign-extend both operands, then add, subtract or pass the centre tap.
    always_comb begin
        a_x = {a[DATA_W-1], a};
        b_x = {b[DATA_W-1], b};
        y   = a_x + b_x;
        if (centre) begin
            y = sub ? '0 : a_x;
        end else if (sub) begin
            y = a_x - b_x;
        end
    end

endmodule

// File: rtl/sym_tap_line.sv
// Symmetric-FIR sample delay line with registered pre-add pair outputs.
// Holds the last TAPS accepted samples (tap[0] newest) and presents
// tap[k] +/- tap[TAPS-1-k] for every pair one cycle after each accept.
// out_valid is held low until the line has been filled with TAPS samples.
// Optional build macro: SYM_TAP_ANTISYM_EN adds the antisym input, which
// selects subtraction for all pairs and zeroes an odd-length centre tap.
module sym_tap_line
    import sym_fir_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int TAPS   = DEF_TAPS
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         in_valid,
    input  logic signed [DATA_W-1:0]                     in_data,
    input  logic                                         flush,
`ifdef SYM_TAP_ANTISYM_EN
    input  logic                                         antisym,
`endif
    output logic                                         out_valid,
    output logic [pairs_f(TAPS)*(DATA_W+1)-1:0]          out_sum,
    output logic [$clog2(TAPS+1)-1:0]                    fill_cnt
);

    localparam int PAIRS = pairs_f(TAPS);
    localparam int PW    = DATA_W + 1;
    localparam int CW    = $clog2(TAPS + 1);
    localparam logic [CW-1:0] FULL = CW'(TAPS);

    // Saturating fill counter increment: sticks at TAPS once primed.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == FULL) ? c : c + 1'b1;
    endfunction

    logic signed [DATA_W-1:0] taps_q [TAPS];
    logic signed [DATA_W-1:0] taps_d [TAPS];
    logic [CW-1:0]            fill_q;
    logic [CW-1:0]            fill_d;
    logic                     out_valid_q;
    logic                     out_valid_d;
    logic [PAIRS*PW-1:0]      out_sum_q;
    logic [PAIRS*PW-1:0]      out_sum_d;
    logic signed [PW-1:0]     pair_w [PAIRS];
    logic                     accept;
    logic                     sub_mode;

    // flush wins over in_valid; a sample arriving with flush is dropped.
    assign accept = in_valid & ~flush;

`ifdef SYM_TAP_ANTISYM_EN
    assign sub_mode = antisym;
`else
    assign sub_mode = 1'b0;
`endif

    // Next-state delay line, fill count and valid pulse.
    always_comb begin
        taps_d      = taps_q;
        fill_d      = fill_q;
        out_valid_d = 1'b0;
        if (flush) begin
            for (int i = 0; i < TAPS; i++) begin
                taps_d[i] = '0;
            end
            fill_d = '0;
        end else if (in_valid) begin
            taps_d[0] = in_data;
            for (int i = 1; i < TAPS; i++) begin
                taps_d[i] = taps_q[i-1];
            end
            fill_d      = sat_inc(fill_q);
            out_valid_d = (fill_d == FULL);
        end
    end

    // Pre-adders work on the next-state taps so sums land with the accept edge.
    for (genvar k = 0; k < PAIRS; k++) begin : g_pair
        localparam bit IS_CENTRE = ((TAPS % 2) == 1) && (k == PAIRS - 1);
        sym_pre_add #(.DATA_W(DATA_W)) u_pre_add (
            .a      (taps_d[k]),
            .b      (taps_d[TAPS-1-k]),
            .sub    (sub_mode),
            .centre (IS_CENTRE),
            .y      (pair_w[k])
        );
    end

    // Pack pair sums on accept; otherwise hold the previous output word.
    always_comb begin
        out_sum_d = out_sum_q;
        if (accept) begin
            for (int k = 0; k < PAIRS; k++) begin
                out_sum_d[k*PW +: PW] = pair_w[k];
            end
        end
    end

    // ---- register stage: line state and outputs ----
    always_ff @(posedge clk) begin
        if (rst) begin
            taps_q      <= '{default: '0};
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
        end else begin
            taps_q      <= taps_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign fill_cnt  = fill_q;

endmodule

// File: tb/tb_sym_tap_line.sv
// Bench for sym_tap_line: an even (TAPS=4) and an odd (TAPS=5) instance
// share one 8-bit stimulus stream and are checked against a behavioural
// model of the sample history every cycle, plus hand-computed pair values.
module tb_sym_tap_line;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              flush = 1'b0;
    logic signed [7:0] in_data = '0;
    bit                anti = 1'b0;

    logic        ov4, ov5;
    logic [17:0] os4;
    logic [26:0] os5;
    logic [2:0]  fc4, fc5;

    always #5 clk = ~clk;

    sym_tap_line #(.DATA_W(8), .TAPS(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .flush     (flush),
`ifdef SYM_TAP_ANTISYM_EN
        .antisym   (anti),
`endif
        .out_valid (ov4),
        .out_sum   (os4),
        .fill_cnt  (fc4)
    );

    sym_tap_line #(.DATA_W(8), .TAPS(5)) u_dut5 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .flush     (flush),
`ifdef SYM_TAP_ANTISYM_EN
        .antisym   (anti),
`endif
        .out_valid (ov5),
        .out_sum   (os5),
        .fill_cnt  (fc5)
    );

    // Model: sample history per instance (index 0 newest), fill count,
    // expected valid and expected packed sums.
    int          hist [2][8];
    int          mfill [2];
    bit          mvld [2];
    logic [26:0] msum [2];
    int          ntaps [2] = '{4, 5};

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    function automatic logic [26:0] pack_pairs(input int l [8], input int n, input bit a);
        logic [26:0] r;
        int v;
        r = '0;
        for (int k = 0; k < (n + 1) / 2; k++) begin
            if ((n % 2 == 1) && (k == (n - 1) / 2)) v = a ? 0 : l[k];
            else v = a ? (l[k] - l[n-1-k]) : (l[k] + l[n-1-k]);
            r[k*9 +: 9] = v[8:0];
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit r_, input bit fl, input bit iv, input int d, input bit a);
        int tmp [8];
        for (int u = 0; u < 2; u++) begin
            if (r_ || fl) begin
                for (int i = 0; i < 8; i++) hist[u][i] = 0;
                mfill[u] = 0;
                mvld[u]  = 1'b0;
                if (r_) msum[u] = '0;
            end else if (iv) begin
                for (int i = 7; i > 0; i--) hist[u][i] = hist[u][i-1];
                hist[u][0] = d;
                if (mfill[u] < ntaps[u]) mfill[u]++;
                mvld[u] = (mfill[u] == ntaps[u]);
                for (int i = 0; i < 8; i++) tmp[i] = hist[u][i];
                msum[u] = pack_pairs(tmp, ntaps[u], a);
            end else begin
                mvld[u] = 1'b0;
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, settle.
    task automatic step(input bit r_, input bit fl, input bit iv, input int d);
        rst      = r_;
        flush    = fl;
        in_valid = iv;
        in_data  = d[7:0];
        @(posedge clk);
        model_update(r_, fl, iv, d, anti);
        #1;
    endtask

    // Every cycle: both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("vld4",  {31'd0, ov4}, {31'd0, mvld[0]});
            chk("fill4", {29'd0, fc4}, mfill[0]);
            chk("sum4",  {14'd0, os4}, {14'd0, msum[0][17:0]});
            chk("vld5",  {31'd0, ov5}, {31'd0, mvld[1]});
            chk("fill5", {29'd0, fc5}, mfill[1]);
            chk("sum5",  {5'd0, os5},  {5'd0, msum[1]});
        end
    end

    initial begin
        step(1, 0, 0, 0);
        chk_en = 1'b1;
        chk("rst_vld4", {31'd0, ov4}, 0);
        chk("rst_sum4", {14'd0, os4}, 0);
        chk("rst_fill5", {29'd0, fc5}, 0);

        // Priming 1..4 then 5, 6
        step(0, 0, 1, 1); chk("prime_vld_1", {31'd0, ov4}, 0);
        step(0, 0, 1, 2); chk("prime_vld_2", {31'd0, ov4}, 0);
        step(0, 0, 1, 3); chk("prime_vld_3", {31'd0, ov4}, 0);
        step(0, 0, 1, 4);
        chk("prime_vld_4", {31'd0, ov4}, 1);
        chk("prime_sum_4", {14'd0, os4}, {14'd0, 9'd5, 9'd5});
        chk("model_pin_4", {14'd0, msum[0][17:0]}, {14'd0, 9'd5, 9'd5});
        chk("odd_not_yet", {31'd0, ov5}, 0);
        step(0, 0, 1, 5);
        chk("b2b_vld", {31'd0, ov4}, 1);
        chk("b2b_sum", {14'd0, os4}, {14'd0, 9'd7, 9'd7});
        chk("odd_vld", {31'd0, ov5}, 1);
        chk("odd_sum", {5'd0, os5}, {5'd0, 9'd3, 9'd6, 9'd6});
        chk("model_pin_5", {5'd0, msum[1]}, {5'd0, 9'd3, 9'd6, 9'd6});
        step(0, 0, 1, 6);
        chk("odd_fill_sat", {29'd0, fc5}, 5);

        // Width extremes
        for (int i = 0; i < 4; i++) step(0, 0, 1, 127);
        chk("max_sum", {14'd0, os4}, {14'd0, 9'd254, 9'd254});
        for (int i = 0; i < 4; i++) step(0, 0, 1, -128);
        chk("min_sum", {14'd0, os4}, {14'd0, 9'h100, 9'h100});

        // Gaps hold output
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("gap_vld", {31'd0, ov4}, 0);
        chk("gap_hold", {14'd0, os4}, {14'd0, 9'h100, 9'h100});

        // Flush beats a same-cycle sample
        step(0, 0, 1, 10);
        step(0, 0, 1, 20);
        step(0, 1, 1, 99);
        chk("flush_fill", {29'd0, fc4}, 0);
        chk("flush_vld", {31'd0, ov4}, 0);
        step(0, 0, 1, 10);
        step(0, 0, 1, 20);
        step(0, 0, 1, 30);
        chk("flush_prime", {31'd0, ov4}, 0);
        step(0, 0, 1, 40);
        chk("flush_vld4", {31'd0, ov4}, 1);
        chk("flush_sum4", {14'd0, os4}, {14'd0, 9'd50, 9'd50});

        // Reset mid-stream
        step(0, 0, 1, 50);
        step(1, 0, 1, 60);
        chk("midrst_vld", {31'd0, ov4}, 0);
        chk("midrst_sum4", {14'd0, os4}, 0);
        chk("midrst_sum5", {5'd0, os5}, 0);
        chk("midrst_fill", {29'd0, fc4}, 0);

`ifdef SYM_TAP_ANTISYM_EN
        anti = 1'b1;
        step(0, 0, 1, 1);
        step(0, 0, 1, 2);
        step(0, 0, 1, 3);
        step(0, 0, 1, 4);
        chk("anti_sum4", {14'd0, os4}, {14'd0, 9'd1, 9'd3});
        step(0, 0, 1, 5);
        chk("anti_sum5", {5'd0, os5}, {5'd0, 9'd0, 9'd2, 9'd4});
        anti = 1'b0;
`endif

        // Random stream
        for (int i = 0; i < 1000; i++) begin
`ifdef SYM_TAP_ANTISYM_EN
            anti = bit'($urandom_range(0, 1));
`endif
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 99) < 3),
                 ($urandom_range(0, 99) < 75),
                 int'($urandom_range(0, 255)) - 128);
        end

        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
